// File: rtl/vdp_cpu_port.sv
// -----------------------------------------------------------------------------
// vdp_cpu_port
//
// CPU-side port of the VGA video display processor. Decodes a TMS9918-style
// data port (BASE_PORT) and control port (BASE_PORT|1) on the Z180 I/O bus.
// It owns the write-only register file, the auto-incrementing VRAM pointer,
// the read prefetch buffer and the status register (frame flag F).
//
// Ports
//   hwclk, reset_n    system clock; synchronous active-low reset
//   a, d_in           CPU address / write data (asynchronous to hwclk)
//   iorq_n,rd_n,wr_n  CPU strobes, asynchronous, active-low
//   d_out, d_oe       registered read data and combinational bus enable
//   vram_addr/wdata   VRAM access address and write data
//   vram_we, vram_re  one-cycle strobes; read data is valid the cycle after vram_re
//   vram_rdata        VRAM read data
//   regs              register file, reg n at [8n+7:8n]
//   vblank            one-cycle pulse at the start of vertical blank
//   int_n             interrupt request, active-low
//
// Build option: define VDP_IRQ_EN to drive int_n from F & reg1[5];
// without it int_n is tied high while F still works.
// -----------------------------------------------------------------------------
module vdp_cpu_port #(
    parameter logic [7:0] BASE_PORT = 8'h80,
    parameter int         NUM_REGS  = 8,
    parameter int         VRAM_AW   = 14
) (
    input  logic                  hwclk,
    input  logic                  reset_n,
    input  logic [7:0]            a,
    input  logic [7:0]            d_in,
    input  logic                  iorq_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    output logic [7:0]            d_out,
    output logic                  d_oe,
    output logic [VRAM_AW-1:0]    vram_addr,
    output logic [7:0]            vram_wdata,
    output logic                  vram_we,
    output logic                  vram_re,
    input  logic [7:0]            vram_rdata,
    output logic [8*NUM_REGS-1:0] regs,
    input  logic                  vblank,
    output logic                  int_n
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,   // vram_re asserted at the pointer
        ST_RD_CAP,   // VRAM data valid: load the prefetch buffer, bump pointer
        ST_WR        // vram_we asserted at the pointer
    } seq_t;

    seq_t state, state_nxt;

    logic [2:0]         strb_meta, strb_sync;   // {iorq, rd, wr}, active-high
    logic [7:0]         a_meta, a_sync;         // address travels with the strobes
    logic               iorq_s, rd_s, wr_s, port_hit;
    logic               wr_acc, rd_acc, wr_commit, rd_commit;
    logic               armed, wr_prev, rd_prev, rd_ctrl;
    logic               flag, status_f;
    logic [7:0]         latch, rbuf;
    logic [VRAM_AW-1:0] addr;
    logic [13:0]        addr_load;
    logic               start_wr, start_pf;
    logic [7:0]         reg_file [NUM_REGS];

    assign {iorq_s, rd_s, wr_s} = strb_sync;
    assign port_hit  = (a_sync[7:1] == BASE_PORT[7:1]);
    assign wr_acc    = iorq_s & wr_s & port_hit;
    assign rd_acc    = iorq_s & rd_s & port_hit;
    // Writes act on the leading edge of the synced strobe, reads on the
    // trailing edge so side effects land after the CPU has taken the data.
    assign wr_commit = armed & wr_acc & ~wr_prev;
    assign rd_commit = armed & rd_prev & ~rd_acc;

    assign d_oe      = ~iorq_n & ~rd_n & (a[7:1] == BASE_PORT[7:1]);
    assign addr_load = {d_in[5:0], latch};
    assign start_wr  = wr_commit & ~a_sync[0];
    assign start_pf  = (wr_commit & a_sync[0] & flag & (d_in[7:6] == 2'b00))
                     | (rd_commit & ~rd_ctrl);

    assign vram_addr = addr;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs[8*g +: 8] = reg_file[g];
    end

    always_ff @(posedge hwclk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = ST_IDLE;
        vram_we   = 1'b0;
        vram_re   = 1'b0;
        case (state)
            ST_RD_REQ: begin
                vram_re   = 1'b1;
                state_nxt = ST_RD_CAP;
            end
            ST_WR:   vram_we = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
        if (start_wr)      state_nxt = ST_WR;
        else if (start_pf) state_nxt = ST_RD_REQ;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge hwclk) begin
        if (!reset_n) begin
            // Strobes reset to "asserted" so one held low across reset is not
            // mistaken for a fresh access; armed waits for a real idle bus.
            strb_meta  <= 3'b111;
            strb_sync  <= 3'b111;
            a_meta     <= '0;
            a_sync     <= '0;
            armed      <= 1'b0;
            wr_prev    <= 1'b0;
            rd_prev    <= 1'b0;
            rd_ctrl    <= 1'b0;
            flag       <= 1'b0;
            status_f   <= 1'b0;
            latch      <= '0;
            rbuf       <= '0;
            addr       <= '0;
            vram_wdata <= '0;
            d_out      <= '0;
            int_n      <= 1'b1;
            // NOTE: the register file is a handful of flops visible on the
            // regs port, so it is reset like any other state, not left as RAM.
            for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
        end else begin
            strb_meta <= {~iorq_n, ~rd_n, ~wr_n};
            strb_sync <= strb_meta;
            a_meta    <= a;
            a_sync    <= a_meta;
            armed     <= armed | ~(iorq_s & (rd_s | wr_s));
            wr_prev   <= wr_acc;
            rd_prev   <= rd_acc;
            if (rd_acc) rd_ctrl <= a_sync[0];

            // Sequencer side effects come first so a pointer load from a
            // commit in the same cycle takes precedence.
            if (state == ST_WR) addr <= addr + VRAM_AW'(1);
            if (state == ST_RD_CAP) begin
                rbuf <= vram_rdata;
                addr <= addr + VRAM_AW'(1);
            end

            if (wr_commit) begin
                if (a_sync[0]) begin
                    if (!flag) begin
                        latch <= d_in;
                        flag  <= 1'b1;
                    end else begin
                        flag <= 1'b0;
                        if (d_in[7]) begin
                            for (int i = 0; i < NUM_REGS; i++)
                                if (d_in[5:0] == 6'(i)) reg_file[i] <= latch;
                        end else begin
                            addr <= addr_load[VRAM_AW-1:0];
                        end
                    end
                end else begin
                    vram_wdata <= d_in;
                    rbuf       <= d_in;
                    flag       <= 1'b0;
                end
            end else if (rd_commit) begin
                flag <= 1'b0;
            end

            // A vblank in the same cycle as a status-read commit wins.
            if (vblank)                   status_f <= 1'b1;
            else if (rd_commit & rd_ctrl) status_f <= 1'b0;

            // Frozen once the synced read is seen; the select uses a_meta so
            // the last update before freezing already reflects this read's port.
            if (!rd_acc) d_out <= a_meta[0] ? {status_f, 7'b0} : rbuf;

`ifdef VDP_IRQ_EN
            int_n <= ~(status_f & reg_file[1][5]);
`else
            int_n <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// -----------------------------------------------------------------------------
// tb_vdp_cpu_port
//
// Drives Z180-style I/O cycles into vdp_cpu_port with a behavioural VRAM
// attached, and compares every observable effect against a transaction-level
// model of the port (pointer, latch/flag, register file, prefetch buffer, F).
// Directed scenarios first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_vdp_cpu_port;

    localparam int         NUM_REGS  = 8;
    localparam int         VRAM_AW   = 14;
    localparam int         DEPTH     = 1 << VRAM_AW;
    localparam logic [7:0] DATA_PORT = 8'h80;
    localparam logic [7:0] CTRL_PORT = 8'h81;

    logic                  hwclk = 1'b0;
    logic                  reset_n;
    logic [7:0]            a, d_in, d_out, vram_wdata, vram_rdata;
    logic                  iorq_n, rd_n, wr_n, d_oe, vram_we, vram_re, vblank, int_n;
    logic [VRAM_AW-1:0]    vram_addr;
    logic [8*NUM_REGS-1:0] regs;

    vdp_cpu_port #(.BASE_PORT(8'h80), .NUM_REGS(NUM_REGS), .VRAM_AW(VRAM_AW)) dut (
        .hwclk(hwclk), .reset_n(reset_n), .a(a), .d_in(d_in),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .d_out(d_out), .d_oe(d_oe),
        .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_we(vram_we), .vram_re(vram_re), .vram_rdata(vram_rdata),
        .regs(regs), .vblank(vblank), .int_n(int_n)
    );

    always #20 hwclk = ~hwclk;

    // Behavioural VRAM with a preload side door.
    logic [7:0]         ram [DEPTH];
    logic               pl_en = 1'b0;
    logic [VRAM_AW-1:0] pl_addr = '0;
    logic [7:0]         pl_data = '0;

    always @(posedge hwclk) begin
        if (pl_en)        ram[pl_addr]   <= pl_data;
        else if (vram_we) ram[vram_addr] <= vram_wdata;
        if (vram_re)      vram_rdata     <= ram[vram_addr];
    end

    // Reference model state.
    logic [7:0] exp_mem [DEPTH];
    logic [7:0] m_regs  [NUM_REGS];
    logic [7:0] m_latch, m_buf;
    bit         m_flag, m_f;
    int         m_addr;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*NUM_REGS-1:0] exp_regs();
        logic [8*NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = m_regs[i];
        return v;
    endfunction

    function automatic logic exp_int_n();
`ifdef VDP_IRQ_EN
        return !(m_f && m_regs[1][5]);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_flag = 0; m_f = 0; m_latch = '0; m_buf = '0; m_addr = 0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    endtask

    task automatic poke(input int addr, input logic [7:0] data);
        @(negedge hwclk);
        pl_en = 1'b1; pl_addr = VRAM_AW'(addr); pl_data = data;
        exp_mem[addr] = data;
        @(negedge hwclk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset(input bit hold_write);
        @(negedge hwclk);
        if (hold_write) begin
            a = CTRL_PORT; d_in = 8'h33; iorq_n = 1'b0; wr_n = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge hwclk);
        check("rst_d_out", d_out, 8'h00);
        check("rst_vram_we", vram_we, 1'b0);
        check("rst_vram_re", vram_re, 1'b0);
        check("rst_vram_addr", vram_addr, '0);
        check("rst_vram_wdata", vram_wdata, 8'h00);
        check("rst_regs", regs, '0);
        check("rst_int_n", int_n, 1'b1);
        reset_n = 1'b1;
        repeat (6) @(negedge hwclk);
        iorq_n = 1'b1; wr_n = 1'b1;
        repeat (6) @(negedge hwclk);
        model_reset();
    endtask

    task automatic cpu_write(input logic [7:0] port, input logic [7:0] data);
        int                 we_cnt, re_cnt, pf_addr;
        logic [VRAM_AW-1:0] we_addr, re_addr;
        logic [7:0]         we_data;
        bit                 hit, exp_pf;
        we_cnt = 0; re_cnt = 0; pf_addr = 0; exp_pf = 0;
        we_addr = '0; re_addr = '0; we_data = '0;
        hit = (port[7:1] == DATA_PORT[7:1]);
        @(negedge hwclk);
        a = port; d_in = data; iorq_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge hwclk);
            if (i == 5) begin iorq_n = 1'b1; wr_n = 1'b1; end
            if (vram_we) begin we_cnt++; we_addr = vram_addr; we_data = vram_wdata; end
            if (vram_re) begin re_cnt++; re_addr = vram_addr; end
        end
        if (hit && !port[0]) begin
            check("wr_we_pulses", we_cnt, 1);
            check("wr_addr", we_addr, m_addr);
            check("wr_data", we_data, data);
            exp_mem[m_addr] = data;
            m_buf  = data;
            m_addr = (m_addr + 1) % DEPTH;
            m_flag = 0;
        end else if (hit) begin
            if (!m_flag) begin
                m_latch = data;
                m_flag  = 1;
            end else begin
                m_flag = 0;
                if (data[7]) begin
                    if (int'(data[5:0]) < NUM_REGS) m_regs[data[5:0]] = m_latch;
                end else begin
                    m_addr = (int'(data[5:0]) * 256 + int'(m_latch)) % DEPTH;
                    if (!data[6]) begin
                        exp_pf  = 1;
                        pf_addr = m_addr;
                        m_buf   = exp_mem[m_addr];
                        m_addr  = (m_addr + 1) % DEPTH;
                    end
                end
            end
            check("ctl_we_pulses", we_cnt, 0);
            check("ctl_re_pulses", re_cnt, exp_pf ? 1 : 0);
            if (exp_pf) check("ctl_pf_addr", re_addr, pf_addr);
        end else begin
            check("foreign_wr_pulses", we_cnt + re_cnt, 0);
        end
        check("vram_addr", vram_addr, m_addr);
        check("regs", regs, exp_regs());
        check("int_n", int_n, exp_int_n());
    endtask

    // vb_commit places a vblank pulse in the same cycle as the read commit
    // (second hwclk after the strobe release has passed the synchroniser).
    task automatic cpu_read(input logic [7:0] port, input bit vb_commit, output logic [7:0] got);
        int                 re_cnt;
        logic [VRAM_AW-1:0] re_addr;
        bit                 hit;
        re_cnt = 0; re_addr = '0; got = '0;
        hit = (port[7:1] == DATA_PORT[7:1]);
        @(negedge hwclk);
        a = port; iorq_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge hwclk);
            if (i == 4) begin
                got = d_out;
                check("d_oe", d_oe, hit);
            end
            if (i == 5) begin iorq_n = 1'b1; rd_n = 1'b1; end
            if (vb_commit && i == 7) vblank = 1'b1;
            if (i == 8) vblank = 1'b0;
            if (vram_re) begin re_cnt++; re_addr = vram_addr; end
        end
        if (hit && !port[0]) begin
            check("data_rd", got, m_buf);
            check("rd_re_pulses", re_cnt, 1);
            check("rd_pf_addr", re_addr, m_addr);
            m_buf  = exp_mem[m_addr];
            m_addr = (m_addr + 1) % DEPTH;
            m_flag = 0;
        end else if (hit) begin
            check("status_rd", got, {m_f, 7'b0});
            check("st_re_pulses", re_cnt, 0);
            m_f    = 0;
            m_flag = 0;
        end else begin
            check("foreign_rd_pulses", re_cnt, 0);
        end
        if (vb_commit) m_f = 1;
        check("vram_addr", vram_addr, m_addr);
        check("int_n", int_n, exp_int_n());
    endtask

    task automatic pulse_vblank();
        @(negedge hwclk);
        vblank = 1'b1;
        @(negedge hwclk);
        vblank = 1'b0;
        m_f = 1;
        repeat (2) @(negedge hwclk);
        check("int_n_vblank", int_n, exp_int_n());
    endtask

    initial begin
        logic [7:0] v, b, port;
        int         op;

        a = '0; d_in = '0; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        vblank = 1'b0; reset_n = 1'b0;

        // Fill VRAM and the model's copy with the same random contents.
        @(negedge hwclk);
        pl_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pl_addr = VRAM_AW'(i);
            pl_data = 8'($urandom);
            exp_mem[i] = pl_data;
            @(negedge hwclk);
        end
        pl_en = 1'b0;

        do_reset(1'b0);
        cpu_read(CTRL_PORT, 1'b0, v);
        check("reset_status", v, 8'h00);

        // Register write, then an out-of-range index that must be ignored.
        cpu_write(CTRL_PORT, 8'h55);
        cpu_write(CTRL_PORT, 8'h87);
        check("reg7", regs[63:56], 8'h55);
        cpu_write(CTRL_PORT, 8'h12);
        cpu_write(CTRL_PORT, 8'h8A);
        check("reg_oob_ignored", regs, {8'h55, 56'h0});

        // Pointer wrap at the top of VRAM.
        cpu_write(CTRL_PORT, 8'hFF);
        cpu_write(CTRL_PORT, 8'h7F);
        cpu_write(DATA_PORT, 8'hA1);
        cpu_write(DATA_PORT, 8'hA2);
        cpu_write(DATA_PORT, 8'hA3);
        check("wrap_addr", vram_addr, 14'h0002);

        // Read-back through the prefetch buffer.
        poke(16'h0100, 8'h11);
        poke(16'h0101, 8'h22);
        cpu_write(CTRL_PORT, 8'h00);
        cpu_write(CTRL_PORT, 8'h01);
        cpu_read(DATA_PORT, 1'b0, v);
        check("rd_first", v, 8'h11);
        cpu_read(DATA_PORT, 1'b0, v);
        check("rd_second", v, 8'h22);

        // Frame flag and interrupt.
        cpu_write(CTRL_PORT, 8'h20);
        cpu_write(CTRL_PORT, 8'h81);
        pulse_vblank();
        cpu_read(CTRL_PORT, 1'b0, v);
        check("status_f_set", v, 8'h80);
        cpu_read(CTRL_PORT, 1'b1, v);
        check("status_before_race", v, 8'h00);
        cpu_read(CTRL_PORT, 1'b0, v);
        check("vblank_wins_race", v, 8'h80);

        // A data read clears a half-written control pair.
        cpu_write(CTRL_PORT, 8'h12);
        cpu_read(DATA_PORT, 1'b0, v);
        cpu_write(CTRL_PORT, 8'h34);
        cpu_write(CTRL_PORT, 8'h82);
        check("flag_cleared_by_read", regs[23:16], 8'h34);

        // Reset during a held control write: the write must be dropped.
        do_reset(1'b1);
        cpu_write(CTRL_PORT, 8'h44);
        cpu_write(CTRL_PORT, 8'h81);
        check("reset_aborts_access", regs[15:8], 8'h44);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            b  = 8'($urandom);
            case (op)
                0, 1, 2: begin
                    if (m_flag) begin
                        case ($urandom_range(0, 2))
                            0:       b = {1'b1, 1'($urandom), 6'($urandom_range(0, 11))};
                            1:       b = {2'b01, b[5:0]};
                            default: b = {2'b00, b[5:0]};
                        endcase
                    end
                    cpu_write(CTRL_PORT, b);
                end
                3, 4:    cpu_write(DATA_PORT, b);
                5, 6:    cpu_read(DATA_PORT, 1'b0, v);
                7:       cpu_read(CTRL_PORT, 1'b0, v);
                8:       pulse_vblank();
                default: begin
                    port = 8'($urandom);
                    if (port[7:1] == DATA_PORT[7:1]) port = port ^ 8'h10;
                    if ($urandom_range(0, 1) == 1) cpu_write(port, b);
                    else                           cpu_read(port, 1'b0, v);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
